// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares the write port of the CDC FIFO between NUM_REQ
// requesters, granting bursts of up to MAX_BURST beats and honouring fifo_full.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int GW        = $clog2(NUM_REQ)
) (
    input  logic                          write_clk,
    input  logic                          write_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          write_enable_in,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          grant_valid,
    output logic [GW-1:0]                 grant_id,
    output logic [15:0]                   beat_count
);

    localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [GW-1:0]           r_grant_id;
    logic [GW-1:0]           r_last_grant;
    logic [BCW-1:0]          r_beat_cnt;
    logic [15:0]             r_beat_count;

    logic [GW-1:0]           w_winner;
    logic                    w_found;
    logic                    w_owner_valid;
    logic [DATA_WIDTH-1:0]   w_owner_data;
    logic                    w_accept;
    logic                    w_release;

    // Round-robin search starting one past the previous owner, wrapping modulo NUM_REQ.
    always_comb begin
        w_winner = {GW{1'b0}};
        w_found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [GW-1:0] idx;
            idx = GW'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && req_valid[idx]) begin
                w_winner = idx;
                w_found  = 1'b1;
            end else begin
                w_found  = w_found;
            end
        end
    end

    assign w_owner_valid = req_valid[r_grant_id];
    assign w_owner_data  = req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
    assign w_accept      = (r_state == ST_GRANT) && w_owner_valid && !fifo_full;
    // A full FIFO only stalls the burst; only a finished burst or an idle owner releases.
    assign w_release     = (w_accept && (r_beat_cnt == BURST_LAST)) || !w_owner_valid;

    // FSM state register; write_rst_n is released synchronously upstream.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_next_state = ST_GRANT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_GRANT;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: the write port only moves while a grant is held and a beat is accepted.
    always_comb begin
        write_enable_in = 1'b0;
        write_data      = {DATA_WIDTH{1'b0}};
        req_ready       = {NUM_REQ{1'b0}};
        grant_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                grant_valid = 1'b0;
            end
            ST_GRANT: begin
                grant_valid     = 1'b1;
                write_enable_in = w_accept;
                if (w_accept) begin
                    write_data = w_owner_data;
                    req_ready  = NUM_REQ'(1) << r_grant_id;
                end else begin
                    write_data = {DATA_WIDTH{1'b0}};
                    req_ready  = {NUM_REQ{1'b0}};
                end
            end
            default: begin
                grant_valid = 1'b0;
            end
        endcase
    end

    // Grant bookkeeping, per-burst beat counter and the free-running accepted-beat total.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            r_grant_id   <= {GW{1'b0}};
            r_last_grant <= GW'(NUM_REQ - 1);
            r_beat_cnt   <= {BCW{1'b0}};
            r_beat_count <= 16'h0000;
        end else begin
            if ((r_state == ST_IDLE) && (|req_valid)) begin
                r_grant_id <= w_winner;
                r_beat_cnt <= {BCW{1'b0}};
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + BCW'(1);
            end else begin
                r_beat_cnt <= r_beat_cnt;
            end
            if ((r_state == ST_GRANT) && w_release) begin
                r_last_grant <= r_grant_id;
            end else begin
                r_last_grant <= r_last_grant;
            end
            if (w_accept) begin
                r_beat_count <= r_beat_count + 16'h0001;
            end else begin
                r_beat_count <= r_beat_count;
            end
        end
    end

    assign grant_id   = r_grant_id;
    assign beat_count = r_beat_count;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed-vector bench for fifo_write_arbiter: one table of per-cycle inputs and
// hand-computed outputs, plus a bounded hand-written burst-length sequence.
module tb_fifo_write_arbiter;

    logic        write_clk = 1'b0;
    logic        write_rst_n = 1'b0;
    logic [3:0]  req_valid = 4'h0;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_ready;
    logic        fifo_full = 1'b0;
    logic        write_enable_in;
    logic [7:0]  write_data;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [15:0] beat_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 write_clk = ~write_clk;

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .write_clk       (write_clk),
        .write_rst_n     (write_rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_full       (fifo_full),
        .write_enable_in (write_enable_in),
        .write_data      (write_data),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id),
        .beat_count      (beat_count)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        full;
        logic        we;
        logic [7:0]  wd;
        logic [3:0]  rdy;
        logic        gv;
        logic [1:0]  gid;
        logic [15:0] bc;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] pk(input logic [7:0] d3, input logic [7:0] d2,
                                       input logic [7:0] d1, input logic [7:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic v(input string name, input logic rst_n, input logic [3:0] valid,
                     input logic [31:0] data, input logic full, input logic we,
                     input logic [7:0] wd, input logic [3:0] rdy, input logic gv,
                     input logic [1:0] gid, input logic [15:0] bc);
        vec_t t;
        t.name = name; t.rst_n = rst_n; t.valid = valid; t.data = data; t.full = full;
        t.we = we; t.wd = wd; t.rdy = rdy; t.gv = gv; t.gid = gid; t.bc = bc;
        vecs.push_back(t);
    endtask

    // Inputs change on the falling edge; outputs are sampled 2ns later, well before the rising edge.
    task automatic drive(input logic rst_n, input logic [3:0] valid, input logic [31:0] data,
                         input logic full);
        @(negedge write_clk);
        write_rst_n = rst_n;
        req_valid   = valid;
        req_data    = data;
        fifo_full   = full;
        #2;
    endtask

    initial begin
        logic [1:0]  ord[5];
        logic [1:0]  prev_gid;
        logic [15:0] bc;
        logic [31:0] rr_data;
        int          burst_len;
        bit          seen_we;

        // Test 1: reset held while every requester is valid.
        v("reset0", 1'b0, 4'hF, pk(8'h33, 8'h22, 8'h11, 8'h01), 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 16'd0);
        v("reset1", 1'b0, 4'hF, pk(8'h33, 8'h22, 8'h11, 8'h01), 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 16'd0);
        v("post_reset_idle", 1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 16'd0);

        // Test 2: single requester 2, two bursts (4 + 2 beats).
        v("single_arb",  1'b1, 4'b0100, pk(8'h00, 8'hA0, 8'h00, 8'h00), 1'b0, 1'b0, 8'h00, 4'h0,    1'b0, 2'd0, 16'd0);
        v("single_b0",   1'b1, 4'b0100, pk(8'h00, 8'hA0, 8'h00, 8'h00), 1'b0, 1'b1, 8'hA0, 4'b0100, 1'b1, 2'd2, 16'd0);
        v("single_b1",   1'b1, 4'b0100, pk(8'h00, 8'hA1, 8'h00, 8'h00), 1'b0, 1'b1, 8'hA1, 4'b0100, 1'b1, 2'd2, 16'd1);
        v("single_b2",   1'b1, 4'b0100, pk(8'h00, 8'hA2, 8'h00, 8'h00), 1'b0, 1'b1, 8'hA2, 4'b0100, 1'b1, 2'd2, 16'd2);
        v("single_b3",   1'b1, 4'b0100, pk(8'h00, 8'hA3, 8'h00, 8'h00), 1'b0, 1'b1, 8'hA3, 4'b0100, 1'b1, 2'd2, 16'd3);
        v("single_gap",  1'b1, 4'b0100, pk(8'h00, 8'hA4, 8'h00, 8'h00), 1'b0, 1'b0, 8'h00, 4'h0,    1'b0, 2'd2, 16'd4);
        v("single_b4",   1'b1, 4'b0100, pk(8'h00, 8'hA4, 8'h00, 8'h00), 1'b0, 1'b1, 8'hA4, 4'b0100, 1'b1, 2'd2, 16'd4);
        v("single_b5",   1'b1, 4'b0100, pk(8'h00, 8'hA5, 8'h00, 8'h00), 1'b0, 1'b1, 8'hA5, 4'b0100, 1'b1, 2'd2, 16'd5);
        v("single_drop", 1'b1, 4'b0000, pk(8'h00, 8'hA6, 8'h00, 8'h00), 1'b0, 1'b0, 8'h00, 4'h0,    1'b1, 2'd2, 16'd6);
        v("single_idle", 1'b1, 4'b0000, 32'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd2, 16'd6);

        // Test 3: fresh reset, then all requesters valid; grants rotate 0,1,2,3,0.
        v("rr_reset", 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 16'd0);
        ord = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_data = pk(8'h53, 8'h52, 8'h51, 8'h50);
        prev_gid = 2'd0;
        bc = 16'd0;
        for (int i = 0; i < 5; i++) begin
            v("rr_idle", 1'b1, 4'hF, rr_data, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, prev_gid, bc);
            for (int b = 0; b < 4; b++) begin
                v("rr_beat", 1'b1, 4'hF, rr_data, 1'b0, 1'b1, 8'h50 + 8'(ord[i]),
                  4'b0001 << ord[i], 1'b1, ord[i], bc);
                bc = bc + 16'd1;
            end
            prev_gid = ord[i];
        end
        v("rr_end", 1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 16'd20);

        // Test 4: requester 1 stalled by fifo_full for 3 cycles after its second beat.
        v("bp_arb",   1'b1, 4'b0010, pk(8'h00, 8'h00, 8'hB0, 8'h00), 1'b0, 1'b0, 8'h00, 4'h0,    1'b0, 2'd0, 16'd20);
        v("bp_b0",    1'b1, 4'b0010, pk(8'h00, 8'h00, 8'hB0, 8'h00), 1'b0, 1'b1, 8'hB0, 4'b0010, 1'b1, 2'd1, 16'd20);
        v("bp_b1",    1'b1, 4'b0010, pk(8'h00, 8'h00, 8'hB1, 8'h00), 1'b0, 1'b1, 8'hB1, 4'b0010, 1'b1, 2'd1, 16'd21);
        v("bp_full0", 1'b1, 4'b0010, pk(8'h00, 8'h00, 8'hB2, 8'h00), 1'b1, 1'b0, 8'h00, 4'h0,    1'b1, 2'd1, 16'd22);
        v("bp_full1", 1'b1, 4'b0010, pk(8'h00, 8'h00, 8'hB2, 8'h00), 1'b1, 1'b0, 8'h00, 4'h0,    1'b1, 2'd1, 16'd22);
        v("bp_full2", 1'b1, 4'b0010, pk(8'h00, 8'h00, 8'hB2, 8'h00), 1'b1, 1'b0, 8'h00, 4'h0,    1'b1, 2'd1, 16'd22);
        v("bp_b2",    1'b1, 4'b0010, pk(8'h00, 8'h00, 8'hB2, 8'h00), 1'b0, 1'b1, 8'hB2, 4'b0010, 1'b1, 2'd1, 16'd22);
        v("bp_b3",    1'b1, 4'b0010, pk(8'h00, 8'h00, 8'hB3, 8'h00), 1'b0, 1'b1, 8'hB3, 4'b0010, 1'b1, 2'd1, 16'd23);
        v("bp_rel",   1'b1, 4'b0000, 32'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd1, 16'd24);

        // Test 5: requester 2 drops valid after 2 beats while 3 waits; no preemption before that.
        v("er_arb",   1'b1, 4'b1100, pk(8'hD0, 8'hC0, 8'h00, 8'h00), 1'b0, 1'b0, 8'h00, 4'h0,    1'b0, 2'd1, 16'd24);
        v("er_c0",    1'b1, 4'b1100, pk(8'hD0, 8'hC0, 8'h00, 8'h00), 1'b0, 1'b1, 8'hC0, 4'b0100, 1'b1, 2'd2, 16'd24);
        v("er_c1",    1'b1, 4'b1100, pk(8'hD0, 8'hC1, 8'h00, 8'h00), 1'b0, 1'b1, 8'hC1, 4'b0100, 1'b1, 2'd2, 16'd25);
        v("er_drop",  1'b1, 4'b1000, pk(8'hD0, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0, 8'h00, 4'h0,    1'b1, 2'd2, 16'd26);
        v("er_idle",  1'b1, 4'b1000, pk(8'hD0, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0, 8'h00, 4'h0,    1'b0, 2'd2, 16'd26);
        v("er_d0",    1'b1, 4'b1000, pk(8'hD0, 8'h00, 8'h00, 8'h00), 1'b0, 1'b1, 8'hD0, 4'b1000, 1'b1, 2'd3, 16'd26);
        v("er_d1",    1'b1, 4'b1000, pk(8'hD1, 8'h00, 8'h00, 8'h00), 1'b0, 1'b1, 8'hD1, 4'b1000, 1'b1, 2'd3, 16'd27);

        // Test 6: reset mid-burst of requester 3, then priority restarts at requester 0.
        v("mr_rst0",  1'b0, 4'b1000, pk(8'hD2, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0, 8'h00, 4'h0,    1'b0, 2'd0, 16'd0);
        v("mr_rst1",  1'b0, 4'b1001, pk(8'hD2, 8'h00, 8'h00, 8'hE0), 1'b0, 1'b0, 8'h00, 4'h0,    1'b0, 2'd0, 16'd0);
        v("mr_arb",   1'b1, 4'b1001, pk(8'hD2, 8'h00, 8'h00, 8'hE0), 1'b0, 1'b0, 8'h00, 4'h0,    1'b0, 2'd0, 16'd0);
        v("mr_e0",    1'b1, 4'b1001, pk(8'hD2, 8'h00, 8'h00, 8'hE0), 1'b0, 1'b1, 8'hE0, 4'b0001, 1'b1, 2'd0, 16'd0);
        v("mr_drop",  1'b1, 4'b0000, 32'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 2'd0, 16'd1);
        v("mr_idle",  1'b1, 4'b0000, 32'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 16'd1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].valid, vecs[i].data, vecs[i].full);
            n_vec++;
            if ({write_enable_in, write_data, req_ready, grant_valid, grant_id, beat_count} !==
                {vecs[i].we, vecs[i].wd, vecs[i].rdy, vecs[i].gv, vecs[i].gid, vecs[i].bc}) begin
                n_err++;
                $display("FAIL %s [%0d]: got we=%b wd=%h rdy=%b gv=%b gid=%0d bc=%0d, want we=%b wd=%h rdy=%b gv=%b gid=%0d bc=%0d",
                         vecs[i].name, i, write_enable_in, write_data, req_ready, grant_valid,
                         grant_id, beat_count, vecs[i].we, vecs[i].wd, vecs[i].rdy,
                         vecs[i].gv, vecs[i].gid, vecs[i].bc);
            end
        end

        // Hand-written: with requester 0 always valid, a burst must stop after exactly 4 writes.
        burst_len = 0;
        seen_we = 1'b0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 4'b0001, pk(8'h00, 8'h00, 8'h00, 8'hF0), 1'b0);
            if (write_enable_in) begin
                seen_we = 1'b1;
                burst_len++;
            end else if (seen_we) begin
                break;
            end
        end
        n_vec++;
        if (!seen_we) begin
            n_err++;
            $display("FAIL burst_timeout: got no write within 20 cycles, want a burst of 4");
        end else if (burst_len != 4) begin
            n_err++;
            $display("FAIL burst_len: got %0d beats, want 4", burst_len);
        end
        n_vec++;
        if (beat_count !== 16'd5 || grant_valid !== 1'b0) begin
            n_err++;
            $display("FAIL burst_gap: got bc=%0d gv=%b, want bc=5 gv=0", beat_count, grant_valid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
